mpu_matrix_streamer: RTL and testbench

MPU_MATRIX_STREAMER -- requirements
Module: mpu_matrix_streamer

---
 rtl/mpu_pkg.sv | 18 +
 rtl/mpu_index_counter.sv | 53 +++++
 rtl/mpu_matrix_streamer.sv | 126 ++++++++++++
 tb/tb_mpu_matrix_streamer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared MPU definitions: matrix geometry, element and flattened-matrix types,
// and the streamer FSM state encoding.
package mpu_pkg;

    localparam int MATRIX_DIM = 5;
    localparam int ELEM_W     = 8;
    localparam int IDX_W      = 3;

    typedef logic [ELEM_W-1:0]                        elem_t;
    typedef logic [MATRIX_DIM*MATRIX_DIM*ELEM_W-1:0]  matrix_t;
    typedef logic [IDX_W-1:0]                         idx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/mpu_index_counter.sv
// Row/column index generator for a DIM x DIM matrix walk.
// order=0 walks row-major (col fastest), order=1 walks column-major (row fastest).
// clear has priority over advance and returns the walk to (0,0).
module mpu_index_counter
    import mpu_pkg::*;
#(
    parameter int DIM = MATRIX_DIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    input  logic order,
    output idx_t row,
    output idx_t col,
    output logic last
);

    localparam idx_t MAX_IDX = idx_t'(DIM - 1);

    // Step the (row, col) pair along the selected order, wrapping at DIM-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (!order) begin
                if (col == MAX_IDX) begin
                    col <= '0;
                    row <= (row == MAX_IDX) ? '0 : row + idx_t'(1);
                end else begin
                    col <= col + idx_t'(1);
                end
            end else begin
                if (row == MAX_IDX) begin
                    row <= '0;
                    col <= (col == MAX_IDX) ? '0 : col + idx_t'(1);
                end else begin
                    row <= row + idx_t'(1);
                end
            end
        end
    end

    // The final element is the same corner in either order.
    always_comb begin
        last = (row == MAX_IDX) && (col == MAX_IDX);
    end

endmodule

// File: rtl/mpu_matrix_streamer.sv
// Captures a flattened DIM x DIM matrix on start and streams its elements
// out in row-major or column-major order over a valid/ready interface.
//
// Handshake: an element transfers on every rising edge where out_valid and
// out_ready are both high. out_valid is a pure function of registered state
// (never of out_ready), and out_data/out_row/out_col/out_last only change after
// a transfer, so they stay stable while the sink stalls.
module mpu_matrix_streamer #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      transpose,
    input  logic [DIM*DIM*ELEM_W-1:0] matrix,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W-1:0]         out_data,
    output logic [2:0]                out_row,
    output logic [2:0]                out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output mpu_pkg::stream_state_e    dbg_state
);

    import mpu_pkg::stream_state_e;
    import mpu_pkg::ST_IDLE;
    import mpu_pkg::ST_STREAM;
    import mpu_pkg::idx_t;

    stream_state_e             state_q, state_d;
    logic                      done_q, done_d;
    logic                      order_q;
    logic [DIM*DIM*ELEM_W-1:0] mat_q;
    logic                      capture;
    logic                      xfer;
    idx_t                      row, col;
    logic                      idx_last;
    int                        elem_idx;
    logic [ELEM_W-1:0]         cur_elem;

    // State and done-pulse registers; reset drops any stream in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Order select is latched with start so mid-stream changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_q <= 1'b0;
        end else if (capture) begin
            order_q <= transpose;
        end
    end

    // Matrix buffer is only ever read while streaming, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            mat_q <= matrix;
        end
    end

    // Next-state logic: start is only honoured in IDLE; the last transfer ends the stream.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        capture = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                xfer = out_ready;
                if (out_ready && idx_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mpu_index_counter #(
        .DIM (DIM)
    ) u_index (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (capture),
        .advance (xfer),
        .order   (order_q),
        .row     (row),
        .col     (col),
        .last    (idx_last)
    );

    // Select the captured element at the current coordinates.
    always_comb begin
        elem_idx = int'(row) * DIM + int'(col);
        cur_elem = mat_q[elem_idx*ELEM_W +: ELEM_W];
    end

    // Outputs are forced to zero outside STREAM so reset clears them immediately.
    always_comb begin
        out_valid = (state_q == ST_STREAM);
        busy      = (state_q == ST_STREAM);
        out_data  = out_valid ? cur_elem : '0;
        out_row   = out_valid ? row : '0;
        out_col   = out_valid ? col : '0;
        out_last  = out_valid && idx_last;
        done      = done_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Directed bench for mpu_matrix_streamer: table of expected stream elements for
// both orders, plus hand-written stall, restart, reset and back-to-back sequences.
module tb_mpu_matrix_streamer;
    import mpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          transpose;
    matrix_t       matrix;
    logic          out_valid;
    logic          out_ready;
    elem_t         out_data;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic          out_last;
    logic          busy;
    logic          done;
    stream_state_e dbg_state;

    always #5 clk = ~clk;

    mpu_matrix_streamer #(
        .DIM    (MATRIX_DIM),
        .ELEM_W (ELEM_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .transpose (transpose),
        .matrix    (matrix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- expected vectors ----------------
    typedef struct {
        logic       tr;
        elem_t      data;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
    } vec_t;

    vec_t    vecs[2*25];
    matrix_t base_matrix;
    int      tests_run = 0;
    int      tests_failed = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic tr);
        start     = 1'b1;
        transpose = tr;
        step();
        start     = 1'b0;
    endtask

    task automatic check_elem(input string tag, input int idx);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " busy"},  32'(busy), 32'd1);
        check({tag, " data"},  32'(out_data), 32'(vecs[idx].data));
        check({tag, " row"},   32'(out_row), 32'(vecs[idx].row));
        check({tag, " col"},   32'(out_col), 32'(vecs[idx].col));
        check({tag, " last"},  32'(out_last), 32'(vecs[idx].last));
    endtask

    task automatic check_done_cycle(input string tag);
        check({tag, " done"},     32'(done), 32'd1);
        check({tag, " valid0"},   32'(out_valid), 32'd0);
        check({tag, " busy0"},    32'(busy), 32'd0);
        check({tag, " idle"},     32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Check a full 25-element stream with out_ready held high; ends on the done cycle.
    task automatic check_stream(input string tag, input logic tr);
        for (int k = 0; k < 25; k++) begin
            check_elem(tag, int'(tr) * 25 + k);
            step();
        end
        check_done_cycle(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, 32'(out_valid), 32'd0);
        check({tag, " data"},  32'(out_data), 32'd0);
        check({tag, " row"},   32'(out_row), 32'd0);
        check({tag, " col"},   32'(out_col), 32'd0);
        check({tag, " last"},  32'(out_last), 32'd0);
        check({tag, " busy"},  32'(busy), 32'd0);
        check({tag, " done"},  32'(done), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int xfers;

        // Matrix (i,j) = 10*i + j.
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                base_matrix[(i*5+j)*8 +: 8] = 8'(10*i + j);

        // Row-major: element k is (k/5, k%5); column-major: element k is (k%5, k/5).
        for (int k = 0; k < 25; k++) begin
            vecs[k].tr   = 1'b0;
            vecs[k].row  = 3'(k / 5);
            vecs[k].col  = 3'(k % 5);
            vecs[k].data = 8'(10*(k / 5) + (k % 5));
            vecs[k].last = (k == 24);
            vecs[25+k].tr   = 1'b1;
            vecs[25+k].row  = 3'(k % 5);
            vecs[25+k].col  = 3'(k / 5);
            vecs[25+k].data = 8'(10*(k % 5) + (k / 5));
            vecs[25+k].last = (k == 24);
        end

        rst_n     = 1'b0;
        start     = 1'b0;
        transpose = 1'b0;
        out_ready = 1'b1;
        matrix    = base_matrix;
        #3;
        check_all_zero("reset");
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        rst_n = 1'b1;
        step();
        check("idle no valid", 32'(out_valid), 32'd0);

        // Row-major and column-major full streams from the vector table.
        pulse_start(1'b0);
        check_stream("rowmaj", 1'b0);
        step();
        check("done pulse ends", 32'(done), 32'd0);
        pulse_start(1'b1);
        check_stream("colmaj", 1'b1);
        step();

        // Sink stalls for 3 cycles on element 12 (value 22 at (2,2) in row-major).
        pulse_start(1'b0);
        xfers = 0;
        for (int k = 0; k < 25; k++) begin
            check_elem("stall", k);
            if (k == 12) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    check_elem("stall hold", 12);
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) xfers++;
            step();
        end
        check("stall xfers", 32'(xfers), 32'd25);
        check_done_cycle("stall");
        step();

        // start and a new matrix mid-stream, and start again on the last transfer.
        pulse_start(1'b0);
        for (int k = 0; k < 25; k++) begin
            check_elem("restart", k);
            if (k == 4) begin
                start  = 1'b1;
                matrix = '1;
                transpose = 1'b1;
            end else if (k == 24) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check_done_cycle("restart");
        step();
        check("no restart", 32'(out_valid), 32'd0);
        matrix    = base_matrix;
        transpose = 1'b0;

        // Asynchronous reset after 10 transfers.
        pulse_start(1'b0);
        for (int k = 0; k < 10; k++) begin
            check_elem("prereset", k);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post rst valid", 32'(out_valid), 32'd0);
        end
        pulse_start(1'b0);
        check_stream("after rst", 1'b0);

        // Back-to-back: start on the done cycle of the previous stream.
        pulse_start(1'b1);
        check_stream("b2b", 1'b1);
        step();
        check("b2b end idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
